// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//
// Registered N-to-2^N select decoder with four operating modes:
//   mode 00 : direct one-hot   - y has exactly the bit at the index active
//   mode 11 : direct thermometer - y has every bit 0..index active
//   mode 01 : scan up          - index steps +1 every DWELL cycles
//   mode 10 : scan down        - index steps -1 every DWELL cycles
// In the direct modes a new index is taken through a valid/ready handshake.
// All outputs except sel_ready come straight from flops so the select lines
// never glitch.
//
// Parameters:
//   N          select width, y is 2^N bits wide (1..6)
//   DWELL      cycles each index stays active while scanning (>=1)
//   ACTIVE_LOW 1 = y is inverted at the output register (inactive = 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         block enable; 0 drives y inactive and freezes index/counter
//   mode       operating mode (see above)
//   sel        index to load in a direct mode
//   sel_valid  sel is valid this cycle
//   sel_ready  combinational: block accepts sel this cycle
//   y          registered decoded select lines
//   y_idx      registered index currently shown on y
//   wrap       one-cycle pulse while y shows a wrapped scan index
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       sel,
    input  logic               sel_valid,
    output logic               sel_ready,
    output logic [(2**N)-1:0]  y,
    output logic [N-1:0]       y_idx,
    output logic               wrap
);

    localparam int W  = 2 ** N;
    // One extra bit keeps the counter at least 1 bit wide when DWELL == 1.
    localparam int CW = $clog2(DWELL) + 1;

    // Operating states; the two scan directions are separate states so that
    // a direction reversal is seen as a fresh scan entry.
    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_DIRECT  = 2'd1;
    localparam logic [1:0] ST_SCAN_UP = 2'd2;
    localparam logic [1:0] ST_SCAN_DN = 2'd3;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_THERMO = 2'b11;

    localparam logic [N-1:0]  IDX_ZERO = {N{1'b0}};
    localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};
    localparam logic [N-1:0]  IDX_ONE  = N'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    // -----------------------------------------------------------------------
    // Encoding helpers
    // -----------------------------------------------------------------------
    function automatic logic [W-1:0] enc_onehot(input logic [N-1:0] idx);
        logic [W-1:0] r;
        r      = {W{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] enc_thermo(input logic [N-1:0] idx);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            r[i] = (N'(i) <= idx);
        end
        return r;
    endfunction

    // Applies output polarity; only y is ever inverted.
    function automatic logic [W-1:0] apply_pol(input logic [W-1:0] v);
        if (ACTIVE_LOW != 0) begin
            return ~v;
        end else begin
            return v;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Registers and next-state signals
    // -----------------------------------------------------------------------
    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  y_r;
    logic [N-1:0]  y_idx_r;
    logic          wrap_r;

    logic          sel_ready_s;
    logic          accept_s;
    logic [1:0]    state_nxt_s;
    logic          scan_entry_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [N-1:0]  idx_nxt_s;
    logic          wrap_nxt_s;
    logic [W-1:0]  y_raw_nxt_s;

    // Handshake ready: only direct modes (mode bits equal) take a new index.
    always_comb begin
        sel_ready_s = en && rst_n && (mode[0] == mode[1]);
        accept_s    = sel_valid && sel_ready_s;
    end

    // State is re-derived every cycle from en and mode.
    always_comb begin
        state_nxt_s = ST_OFF;
        if (!en) begin
            state_nxt_s = ST_OFF;
        end else begin
            case (mode)
                MODE_ONEHOT: state_nxt_s = ST_DIRECT;
                MODE_THERMO: state_nxt_s = ST_DIRECT;
                MODE_UP:     state_nxt_s = ST_SCAN_UP;
                MODE_DOWN:   state_nxt_s = ST_SCAN_DN;
                default:     state_nxt_s = ST_OFF;
            endcase
        end
        // Any transition into a scan state (including a direction change)
        // restarts the dwell period at the current index.
        scan_entry_s = (state_nxt_s != state_r);
    end

    // Index, dwell counter, wrap and raw (pre-polarity) select computation.
    always_comb begin
        idx_nxt_s   = y_idx_r;
        cnt_nxt_s   = cnt_r;
        wrap_nxt_s  = 1'b0;
        y_raw_nxt_s = {W{1'b0}};
        case (state_nxt_s)
            ST_OFF: begin
                // Index and counter are frozen, outputs inactive.
                idx_nxt_s   = y_idx_r;
                cnt_nxt_s   = cnt_r;
                y_raw_nxt_s = {W{1'b0}};
            end
            ST_DIRECT: begin
                cnt_nxt_s = CNT_ZERO;
                if (accept_s) begin
                    idx_nxt_s = sel;
                end else begin
                    idx_nxt_s = y_idx_r;
                end
                // Re-encoded every cycle so a 00<->11 switch takes effect
                // on the held index without a new accept.
                if (mode == MODE_THERMO) begin
                    y_raw_nxt_s = enc_thermo(idx_nxt_s);
                end else begin
                    y_raw_nxt_s = enc_onehot(idx_nxt_s);
                end
            end
            ST_SCAN_UP, ST_SCAN_DN: begin
                if (scan_entry_s) begin
                    cnt_nxt_s = CNT_ZERO;
                    idx_nxt_s = y_idx_r;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (state_nxt_s == ST_SCAN_UP) begin
                        idx_nxt_s  = y_idx_r + IDX_ONE;
                        wrap_nxt_s = (y_idx_r == IDX_MAX);
                    end else begin
                        idx_nxt_s  = y_idx_r - IDX_ONE;
                        wrap_nxt_s = (y_idx_r == IDX_ZERO);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    idx_nxt_s = y_idx_r;
                end
                y_raw_nxt_s = enc_onehot(idx_nxt_s);
            end
            default: begin
                idx_nxt_s   = y_idx_r;
                cnt_nxt_s   = CNT_ZERO;
                wrap_nxt_s  = 1'b0;
                y_raw_nxt_s = {W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            cnt_r   <= CNT_ZERO;
            y_idx_r <= IDX_ZERO;
            wrap_r  <= 1'b0;
            y_r     <= apply_pol({W{1'b0}});
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            y_idx_r <= idx_nxt_s;
            wrap_r  <= wrap_nxt_s;
            y_r     <= apply_pol(y_raw_nxt_s);
        end
    end

    assign sel_ready = sel_ready_s;
    assign y         = y_r;
    assign y_idx     = y_idx_r;
    assign wrap      = wrap_r;

endmodule
